// File: rtl/pwm_pkg.sv
// Shared types for the PWM bank: duty-load FSM states and counter alignment modes.
package pwm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ARMED = 2'd2
  } state_e;

  typedef enum logic {
    MODE_EDGE   = 1'b0,
    MODE_CENTER = 1'b1
  } mode_e;

endpackage : pwm_pkg

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, edge/center up-down counter, period boundary
// and frame_start generation. Mode and prescale are latched only at boundaries.
module pwm_timebase
  import pwm_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PSW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_enable,
  input  logic              i_mode,
  input  logic [PSW-1:0]    i_prescale,
  output logic [DWIDTH-1:0] o_cnt,
  output mode_e             o_mode,
  output logic              o_run,
  output logic              o_boundary,
  output logic              o_frame_start
);

  // Highest counter value, M-1.
  localparam logic [DWIDTH-1:0] TOP = {{(DWIDTH-1){1'b1}}, 1'b0};

  logic [PSW-1:0]    r_pre;
  logic [PSW-1:0]    r_psc;
  logic [DWIDTH-1:0] r_cnt;
  logic              r_dir;
  logic              r_run;
  logic              r_first;
  logic              r_fs;
  mode_e             r_mode;

  logic w_tick;
  logic w_wrap;
  logic w_boundary;

  assign w_tick     = r_run && (r_pre == r_psc);
  assign w_wrap     = (r_mode == MODE_EDGE) ? (r_cnt == TOP) : (r_dir && (r_cnt == '0));
  assign w_boundary = i_enable && (!r_run || (w_tick && w_wrap));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre   <= '0;
      r_psc   <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_run   <= 1'b0;
      r_first <= 1'b0;
      r_fs    <= 1'b0;
      r_mode  <= MODE_EDGE;
    end else begin
      r_fs <= i_enable && r_first;
      if (!i_enable) begin
        r_pre   <= '0;
        r_cnt   <= '0;
        r_dir   <= 1'b0;
        r_run   <= 1'b0;
        r_first <= 1'b0;
      end else if (w_boundary) begin
        r_pre   <= '0;
        r_cnt   <= '0;
        r_dir   <= 1'b0;
        r_run   <= 1'b1;
        r_first <= 1'b1;
        r_mode  <= mode_e'(i_mode);
        r_psc   <= i_prescale;
      end else begin
        r_first <= 1'b0;
        if (w_tick) begin
          r_pre <= '0;
          if (r_mode == MODE_EDGE) begin
            r_cnt <= r_cnt + DWIDTH'(1);
          end else if (!r_dir) begin
            // The peak value is held for a second tick as the count turns down.
            if (r_cnt == TOP) r_dir <= 1'b1;
            else              r_cnt <= r_cnt + DWIDTH'(1);
          end else begin
            r_cnt <= r_cnt - DWIDTH'(1);
          end
        end else begin
          r_pre <= r_pre + PSW'(1);
        end
      end
    end
  end

  assign o_cnt         = r_cnt;
  assign o_mode        = r_mode;
  assign o_run         = r_run;
  assign o_boundary    = w_boundary;
  assign o_frame_start = r_fs;

endmodule : pwm_timebase

// File: rtl/pwm_bank.sv
// Multi-channel PWM bank: serial duty loading into shadow registers, atomic
// commit to active duties at a period boundary, registered compare outputs.
module pwm_bank
  import pwm_pkg::*;
#(
  parameter int CH     = 8,
  parameter int DWIDTH = 8,
  parameter int PSW    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              mode,
  input  logic [PSW-1:0]    prescale,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DWIDTH-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              frame_start,
  output logic [CH-1:0]     out
);

  localparam int             IDXW = (CH > 1) ? $clog2(CH) : 1;
  localparam logic [IDXW-1:0] LAST = IDXW'(CH - 1);

  state_e            r_state;
  state_e            w_next;
  logic [IDXW-1:0]   r_idx;
  logic [DWIDTH-1:0] r_shadow [CH];
  logic [DWIDTH-1:0] r_active [CH];
  logic [CH-1:0]     r_out;

  logic [DWIDTH-1:0] w_cnt;
  mode_e             w_mode;
  logic              w_run;
  logic              w_boundary;
  logic              w_frame_start;
  logic              w_accept;
  logic              w_commit;
  logic [CH-1:0]     w_cmp;

  pwm_timebase #(
    .DWIDTH (DWIDTH),
    .PSW    (PSW)
  ) u_timebase (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_enable      (enable),
    .i_mode        (mode),
    .i_prescale    (prescale),
    .o_cnt         (w_cnt),
    .o_mode        (w_mode),
    .o_run         (w_run),
    .o_boundary    (w_boundary),
    .o_frame_start (w_frame_start)
  );

  assign w_accept = in_valid && in_ready;
  // With the timebase stopped there is no boundary to wait for.
  assign w_commit = (r_state == ST_ARMED) && (w_boundary || !enable);

  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned and infers a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_next = ST_LOAD;
      ST_LOAD:  if (w_accept && (r_idx == LAST)) w_next = ST_ARMED;
      ST_ARMED: if (w_commit) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: shadow and active duties are small register arrays that must come
  // up as zero, so they are reset like any other flop rather than left as RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
      for (int i = 0; i < CH; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      if ((r_state == ST_IDLE) && start) r_idx <= '0;
      if (w_accept) begin
        r_shadow[r_idx] <= in_data;
        r_idx           <= r_idx + IDXW'(1);
      end
      if (w_commit) begin
        for (int i = 0; i < CH; i++) r_active[i] <= r_shadow[i];
      end
    end
  end

  // Center compare cnt >= M-duty, where M-duty is simply ~duty.
  always_comb begin
    w_cmp = '0;
    for (int i = 0; i < CH; i++) begin
      w_cmp[i] = (w_mode == MODE_CENTER) ? (w_cnt >= ~r_active[i]) : (w_cnt < r_active[i]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 r_out <= '0;
    else if (!enable || !w_run) r_out <= '0;
    else                        r_out <= w_cmp;
  end

  assign out         = r_out;
  assign busy        = (r_state != ST_IDLE);
  assign in_ready    = (r_state == ST_LOAD);
  assign frame_start = w_frame_start;

endmodule : pwm_bank

// File: tb/tb_pwm_bank.sv
// Directed self-checking bench for pwm_bank (CH=8, DWIDTH=8): duty loading,
// edge/center high times, mid-period reload, enable gating and reset abort.
module tb_pwm_bank;

  localparam int CH     = 8;
  localparam int DWIDTH = 8;
  localparam int PSW    = 8;

  logic              clk;
  logic              rst_n;
  logic              enable;
  logic              mode;
  logic [PSW-1:0]    prescale;
  logic              start;
  logic              in_valid;
  logic [DWIDTH-1:0] in_data;
  logic              in_ready;
  logic              busy;
  logic              frame_start;
  logic [CH-1:0]     out;

  int n_checks = 0;
  int n_pass   = 0;

  int hi [CH];
  int period;
  int first_hi0;
  int last_hi0;
  int n;

  localparam logic [63:0] WORDS_A = 64'hFFFE_C080_4010_0100;
  localparam logic [63:0] WORDS_B = 64'h8080_8080_8080_8080;
  localparam logic [63:0] WORDS_C = 64'h8070_6050_4030_2010;
  localparam logic [63:0] WORDS_D = 64'h8080_8080_01FF_0040;

  int exp_a [CH] = '{0, 1, 16, 64, 128, 192, 254, 255};

  pwm_bank #(
    .CH     (CH),
    .DWIDTH (DWIDTH),
    .PSW    (PSW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .mode        (mode),
    .prescale    (prescale),
    .start       (start),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .busy        (busy),
    .frame_start (frame_start),
    .out         (out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic wait_fs();
    int g = 0;
    while (!frame_start && g < 5000) begin
      @(negedge clk);
      g++;
    end
    check("fs_seen", 32'(frame_start), 1);
  endtask

  // Counts high cycles per channel from one frame_start up to the next.
  task automatic measure();
    for (int i = 0; i < CH; i++) hi[i] = 0;
    first_hi0 = -1;
    last_hi0  = -1;
    period    = 0;
    wait_fs();
    do begin
      for (int i = 0; i < CH; i++) hi[i] += int'(out[i]);
      if (out[0]) begin
        if (first_hi0 < 0) first_hi0 = period;
        last_hi0 = period;
      end
      period++;
      @(negedge clk);
    end while (!frame_start && period < 5000);
  endtask

  task automatic load(input logic [63:0] words, input bit gaps, input bit poke);
    int k     = 0;
    int guard = 0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (k < CH && guard < 200) begin
      guard++;
      start    = poke && (guard == 3);
      in_valid = !(gaps && (guard % 3 == 0));
      in_data  = words[8*k +: 8];
      if (in_valid && in_ready) k++;
      @(negedge clk);
    end
    start = 1'b0;
    if (poke) begin
      in_valid = 1'b1;
      in_data  = 8'h11;
      for (int j = 0; j < 3; j++) begin
        check($sformatf("ready_after_8_%0d", j), 32'(in_ready), 0);
        @(negedge clk);
      end
    end
    in_valid = 1'b0;
    check("words_taken", k, CH);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    enable   = 1'b0;
    mode     = 1'b0;
    prescale = '0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    repeat (3) @(negedge clk);
    check("rst_out", 32'(out), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_ready", 32'(in_ready), 0);
    check("rst_fs", 32'(frame_start), 0);
    rst_n = 1'b1;

    // Edge mode, prescale 0, duties committed while stopped.
    load(WORDS_A, 1'b0, 1'b0);
    @(negedge clk);
    check("idle_commit_busy", 32'(busy), 0);
    enable = 1'b1;
    measure();
    for (int i = 0; i < CH; i++) check($sformatf("edge_hi%0d", i), hi[i], exp_a[i]);
    check("edge_period", period, 255);

    // Enable dropped mid-period, then restored.
    repeat (30) @(negedge clk);
    check("run_out7", 32'(out[7]), 1);
    enable = 1'b0;
    @(negedge clk);
    check("dis_out", 32'(out), 0);
    check("dis_fs", 32'(frame_start), 0);
    repeat (5) @(negedge clk);
    enable = 1'b1;
    n = 0;
    while (!frame_start && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("reen_fs_lat", n, 2);
    measure();
    check("reen_hi2", hi[2], 16);
    check("reen_hi6", hi[6], 254);
    check("reen_period", period, 255);

    // Reload mid-period: current period keeps old duties.
    fork
      measure();
      begin
        repeat (20) @(negedge clk);
        load(WORDS_B, 1'b0, 1'b0);
        check("armed_busy", 32'(busy), 1);
      end
    join
    for (int i = 0; i < CH; i++) check($sformatf("old_hi%0d", i), hi[i], exp_a[i]);
    check("commit_busy", 32'(busy), 0);
    check("commit_out", 32'(out), 32'hFF);
    measure();
    for (int i = 0; i < CH; i++) check($sformatf("new_hi%0d", i), hi[i], 128);

    // Gapped load with start re-pulsed and a ninth word offered.
    load(WORDS_C, 1'b1, 1'b1);
    check("gap_armed_busy", 32'(busy), 1);
    wait_fs();
    measure();
    for (int i = 0; i < CH; i++) check($sformatf("gap_hi%0d", i), hi[i], 16 * (i + 1));

    // Mode/prescale changed mid-period only apply from the next period.
    fork
      measure();
      begin
        repeat (10) @(negedge clk);
        mode     = 1'b1;
        prescale = 8'd3;
        load(WORDS_D, 1'b0, 1'b0);
      end
    join
    check("mid_change_period", period, 255);
    check("mid_change_hi7", hi[7], 128);
    measure();
    check("ctr_period", period, 2040);
    check("ctr_hi0", hi[0], 512);
    check("ctr_hi1", hi[1], 0);
    check("ctr_hi2", hi[2], 2040);
    check("ctr_hi3", hi[3], 8);
    check("ctr_hi4", hi[4], 1024);
    check("ctr_first_hi0", first_hi0, 764);
    check("ctr_last_hi0", last_hi0, 1275);

    // Reset in the middle of a load.
    repeat (20) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 8'h55;
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("partial_busy", 32'(busy), 1);
    check("partial_out2", 32'(out[2]), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_out", 32'(out), 0);
    check("async_busy", 32'(busy), 0);
    check("async_ready", 32'(in_ready), 0);
    check("async_fs", 32'(frame_start), 0);
    mode     = 1'b0;
    prescale = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    load(WORDS_A, 1'b0, 1'b0);
    check("post_rst_armed", 32'(busy), 1);
    measure();
    for (int i = 0; i < CH; i++) check($sformatf("post_rst_hi%0d", i), hi[i], exp_a[i]);
    check("post_rst_period", period, 255);
    check("post_rst_busy", 32'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pwm_bank

// File: doc/pwm_bank.md
PWM_BANK -- requirements
Module: pwm_bank

Interface
REQ-001 SHALL have parameter CH, default 8, number of PWM channels.
REQ-002 SHALL have parameter DWIDTH, default 8, duty word width; M = 2^DWIDTH-1.
REQ-003 SHALL have parameter PSW, default 8, prescaler width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port enable  input  1  run timebase; 0 = hold counters at 0 and drive outputs low.
REQ-007 SHALL have port mode  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-008 SHALL have port prescale  input  PSW  tick every prescale+1 clk cycles.
REQ-009 SHALL have port start  input  1  one-cycle pulse; begins a CH-word duty load.
REQ-010 SHALL have port in_valid  input  1  in_data valid.
REQ-011 SHALL have port in_data  input  DWIDTH  duty word, channel 0 first.
REQ-012 SHALL have port in_ready  output  1  bank accepts in_data.
REQ-013 SHALL have port busy  output  1  load or commit pending.
REQ-014 SHALL have port frame_start  output  1  one-cycle pulse at each period start.
REQ-015 SHALL have port out  output  CH  registered PWM outputs.

Function
REQ-016 SHALL implement FSM IDLE -> LOAD on start; LOAD -> ARMED after the CH-th accepted word; ARMED -> IDLE on commit.
REQ-017 SHALL assert in_ready only in LOAD, from the cycle after start; word accepted when in_valid && in_ready; index increments per accepted word.
REQ-018 SHALL write accepted words to shadow registers only; active duties are never written during LOAD.
REQ-019 SHALL commit all CH shadow words to active duties together at the next period boundary when enable=1, or the cycle after entering ARMED when enable=0.
REQ-020 SHALL ignore start in LOAD and ARMED; busy = (state != IDLE).
REQ-021 SHALL sample mode and prescale only at period boundaries; mid-period changes take effect next period.
REQ-022 Edge mode SHALL count 0..M-1 per tick, wrapping; out[i] = (cnt < duty[i]); period M ticks.
REQ-023 Center mode SHALL count 0..M-1 up then M-1..0 down (each value twice); out[i] = (cnt >= M-duty[i]); period 2M ticks.
REQ-024 SHALL give duty 0 -> constant low; duty M -> constant high; high time duty*(prescale+1) clk cycles (edge), 2*duty*(prescale+1) (center).
REQ-025 SHALL register out one cycle after the counter value; frame_start pulses on the first tick of each period, aligned with that out update.
REQ-026 SHALL, on enable falling, drive out low and clear counters next cycle; on enable rising, start a new period with frame_start on its first tick.

Reset
REQ-027 SHALL, on rst_n low, immediately clear out, in_ready, busy, frame_start, counters, prescaler, shadow and active duties to 0, and FSM to IDLE.
REQ-028 SHALL discard a partial load on reset; the first load after release SHALL behave as from power-up.

Structure
REQ-029 SHALL place the FSM state enum and mode enum in shared package pwm_pkg.
REQ-030 SHALL use one sub-module pwm_timebase: prescaler, up/down counter, period-boundary and frame_start generation.

Verification (CH=8, DWIDTH=8)
REQ-031 Edge, prescale=0, load 00,01,10,40,80,C0,FE,FF -> high cycles per period 0,1,16,64,128,192,254,255; frame_start every 255 cycles.
REQ-032 Center, prescale=3, duty 0x40 -> 512 high cycles per 2040-cycle period, high window centred on counter peak.
REQ-033 Reload all-0x80 mid-period -> current period unchanged; new duties from the next frame_start; busy falls that cycle.
REQ-034 in_valid with gaps, start re-pulsed during LOAD, ninth word offered -> exactly 8 words taken, start ignored, in_ready low after eighth.
REQ-035 rst_n low after 3 words -> out=0, busy=0 immediately; after release a full 8-word load and commit succeed.
REQ-036 enable low mid-period -> out low next cycle; re-enable -> frame_start on first tick, correct duty cycles resume.
